// File: rtl/mult_pkg.sv
// Shared types and constants for the iterative shift-and-add multiplier.
// The state encoding matches the iterative divider so one sequencer can drive both.
package mult_pkg;

  localparam int MULT_N_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mult_state_e;

  // One extra bit so the counter can hold N itself without wrapping.
  function automatic int calc_cw(input int n);
    return $clog2(n) + 32'sd1;
  endfunction

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter for the multiplier.
// Sync clear wins over enable, and zN flags the last iteration (Q == N-1).
module mult_iter_counter
  import mult_pkg::*;
#(
  parameter int N  = MULT_N_DEF,
  parameter int CW = calc_cw(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          E,
  input  logic          sclr,
  output logic [CW-1:0] Q,
  output logic          zN
);

  logic [CW-1:0] q_r;

  // counter register: reset, then clear, then count
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= {CW{1'b0}};
    end else if (sclr) begin
      q_r <= {CW{1'b0}};
    end else if (E) begin
      q_r <= q_r + CW'(1);
    end else begin
      q_r <= q_r;
    end
  end

  assign Q  = q_r;
  assign zN = (q_r == CW'(N - 1));

endmodule

// File: rtl/iterative_multiplier.sv
// Unsigned N-bit shift-and-add multiplier with a start/done handshake.
// Fixed latency of N iterations; operands are captured only on the load edge.
module iterative_multiplier
  import mult_pkg::*;
#(
  parameter int N = MULT_N_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           s,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic [2*N-1:0] P,
  output logic           done
);

  localparam int CW = calc_cw(N);

  mult_state_e     state_r;
  mult_state_e     state_nxt_s;
  logic            load_s;
  logic            iter_s;
  logic [2*N-1:0]  areg_r;
  logic [N-1:0]    breg_r;
  logic [2*N-1:0]  p_r;
  logic            done_r;
  logic [CW-1:0]   cnt_s;
  logic            last_s;

  mult_iter_counter #(
    .N  (N),
    .CW (CW)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .E     (iter_s),
    .sclr  (load_s),
    .Q     (cnt_s),
    .zN    (last_s)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state and datapath control
  always_comb begin
    state_nxt_s = IDLE;
    load_s      = 1'b0;
    iter_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (s) begin
          load_s      = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        iter_s = 1'b1;
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        // holding s keeps us here so a held request cannot re-trigger
        if (s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // operand, product and done registers
  always_ff @(posedge clk) begin
    if (reset) begin
      areg_r <= {(2*N){1'b0}};
      breg_r <= {N{1'b0}};
      p_r    <= {(2*N){1'b0}};
      done_r <= 1'b0;
    end else begin
      if (load_s) begin
        areg_r <= {{N{1'b0}}, A};
        breg_r <= B;
        p_r    <= {(2*N){1'b0}};
      end else if (iter_s) begin
        if (breg_r[0]) begin
          p_r <= p_r + areg_r;
        end else begin
          p_r <= p_r;
        end
        areg_r <= areg_r << 1;
        breg_r <= breg_r >> 1;
      end else begin
        areg_r <= areg_r;
        breg_r <= breg_r;
        p_r    <= p_r;
      end
      done_r <= (state_nxt_s == DONE);
    end
  end

  assign P    = p_r;
  assign done = done_r;

endmodule

// File: tb/tb_iterative_multiplier.sv
// Scoreboard bench for iterative_multiplier: expected products are queued at start
// and popped when done rises; latency, hold, mid-run reset and an exhaustive sweep.
module tb_iterative_multiplier;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           s = 1'b0;
  logic [N-1:0]   A = '0;
  logic [N-1:0]   B = '0;
  logic [2*N-1:0] P;
  logic           done;

  int checks = 0;
  int errors = 0;
  int txn_cnt = 0;
  int rise_cnt = 0;
  logic done_q = 1'b0;
  logic [2*N-1:0] sb_q[$];

  iterative_multiplier #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .s     (s),
    .A     (A),
    .B     (B),
    .P     (P),
    .done  (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    done_q <= done;
    if (done && !done_q) rise_cnt <= rise_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] ea;
    logic [2*N-1:0] eb;
    ea = a;
    eb = b;
    return ea * eb;
  endfunction

  // wait up to a bounded number of edges for done; returns edges waited
  task automatic wait_done(input bit scramble, output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      if (scramble) begin
        A = N'($urandom);
        B = N'($urandom);
      end
      tick();
      lat++;
    end
  endtask

  // one full pulsed-start transaction, ending back in IDLE
  task automatic do_txn(input logic [N-1:0] a, input logic [N-1:0] b, input bit scramble, input string tag);
    int lat;
    logic [2*N-1:0] exp_p;
    A = a;
    B = b;
    s = 1'b1;
    sb_q.push_back(ref_mul(a, b));
    tick();
    check_eq({tag, "_done_low_at_load"}, done, 1'b0);
    s = 1'b0;
    wait_done(scramble, lat);
    check_eq({tag, "_latency"}, lat, N);
    exp_p = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    check_eq({tag, "_product"}, P, exp_p);
    txn_cnt++;
    tick();
    check_eq({tag, "_done_clear"}, done, 1'b0);
    check_eq({tag, "_p_hold"}, P, exp_p);
  endtask

  initial begin
    int lat;
    logic [2*N-1:0] exp_p;

    // reset state
    tick();
    tick();
    check_eq("rst_p", P, 0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_state", dut.state_r, 2'b00);
    reset = 1'b0;
    tick();

    // directed products
    do_txn(4'd13, 4'd11, 1'b0, "p143");
    check_eq("p143_value", P, 8'h8F);
    do_txn(4'd15, 4'd15, 1'b0, "p225");
    check_eq("p225_value", P, 8'hE1);
    do_txn(4'd0, 4'd9, 1'b0, "zero_a");
    do_txn(4'd9, 4'd1, 1'b0, "b_one");

    // held start: stay in DONE while s is high
    A = 4'd3;
    B = 4'd5;
    s = 1'b1;
    sb_q.push_back(ref_mul(4'd3, 4'd5));
    tick();
    wait_done(1'b0, lat);
    check_eq("hold_latency", lat, N);
    exp_p = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    check_eq("hold_product", P, exp_p);
    txn_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("hold_done_high", done, 1'b1);
      check_eq("hold_p_stable", P, 8'd15);
    end
    s = 1'b0;
    tick();
    check_eq("hold_release_done", done, 1'b0);
    check_eq("hold_release_state", dut.state_r, 2'b00);
    do_txn(4'd6, 4'd7, 1'b0, "after_hold");

    // reset during the second RUN iteration discards the product
    A = 4'd7;
    B = 4'd6;
    s = 1'b1;
    tick();
    s = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midrst_state", dut.state_r, 2'b00);
    check_eq("midrst_p", P, 0);
    check_eq("midrst_done", done, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("midrst_no_done", done, 1'b0);
    end
    do_txn(4'd7, 4'd6, 1'b0, "restart");

    // operands changing during RUN must not matter
    do_txn(4'd10, 4'd12, 1'b1, "scramble");
    check_eq("scramble_value", P, 8'd120);

    // exhaustive sweep
    for (int a = 0; a < (1 << N); a++) begin
      for (int b = 0; b < (1 << N); b++) begin
        do_txn(N'(a), N'(b), 1'b0, "sweep");
      end
    end

    tick();
    check_eq("done_rises", rise_cnt, txn_cnt);
    check_eq("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
